ps2_key_decoder: RTL

Receives the raw PS/2 keyboard clock/data pair, deframes 11-bit scan-code frames and decodes Scan Code Set 2 prefixes into `keycode`, `key_make` and `key_ext`. These are the key-event signals the game processor consumes. The block sits between the board's PS/2 pins and `processor`. It is the sending side of the processor's keyboard interface, and it holds each event's outputs stable until the next event.

---
 rtl/ps2_key_decoder_pkg.sv | 33 +++
 rtl/ps2_key_decoder_rx_frame.sv | 139 +++++++++++++
 rtl/ps2_key_decoder.sv | 90 +++++++++
 3 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared encodings for the PS/2 key decoder: frame and prefix FSM states
// plus the Scan Code Set 2 prefix and device-response byte values.
package ps2_key_decoder_pkg;

    typedef enum logic [1:0] {
        F_IDLE  = 2'd0,
        F_BITS  = 2'd1,
        F_CHECK = 2'd2
    } frame_state_t;

    typedef enum logic [1:0] {
        P_NONE = 2'd0,
        P_E0   = 2'd1,
        P_F0   = 2'd2,
        P_E0F0 = 2'd3
    } prefix_state_t;

    localparam logic [7:0] BYTE_E0 = 8'hE0;
    localparam logic [7:0] BYTE_F0 = 8'hF0;

    localparam logic [7:0] RESP_ACK    = 8'hFA;
    localparam logic [7:0] RESP_BAT_OK = 8'hAA;
    localparam logic [7:0] RESP_ECHO   = 8'hEE;
    localparam logic [7:0] RESP_RESEND = 8'hFE;
    localparam logic [7:0] RESP_ERR0   = 8'h00;
    localparam logic [7:0] RESP_ERR1   = 8'hFF;

    function automatic logic is_response(input logic [7:0] b);
        return (b == RESP_ACK)    || (b == RESP_BAT_OK) || (b == RESP_ECHO) ||
               (b == RESP_RESEND) || (b == RESP_ERR0)   || (b == RESP_ERR1);
    endfunction

endpackage

// File: rtl/ps2_key_decoder_rx_frame.sv
// PS/2 receive front end: pin synchronizers, clock glitch filter, 11-bit
// frame deframer with parity/stop checking and an inter-edge timeout.
module ps2_rx_frame
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_rdy,
    output logic       rx_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic          clk_s1, clk_s2, data_s1, data_s2;
    logic          clk_filt;
    logic [FW-1:0] filt_cnt;
    logic [TW-1:0] to_cnt;
    logic          filt_flip, fall, edge_seen, timeout;

    frame_state_t  state, next_state;
    logic [3:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_bit, stop_bit;

    // Idle PS/2 bus level is high, so the conditioning chain resets to 1.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            data_s1  <= 1'b1;
            data_s2  <= 1'b1;
            clk_filt <= 1'b1;
            filt_cnt <= '0;
        end else begin
            clk_s1  <= ps2_clk;
            clk_s2  <= clk_s1;
            data_s1 <= ps2_data;
            data_s2 <= data_s1;
            if (clk_s2 == clk_filt) begin
                filt_cnt <= '0;
            end else if (filt_flip) begin
                clk_filt <= clk_s2;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + 1'b1;
            end
        end
    end

    assign filt_flip = (clk_s2 != clk_filt) && (filt_cnt == FW'(FILTER_LEN - 1));
    assign edge_seen = filt_flip;
    assign fall      = filt_flip && !clk_s2;
    assign timeout   = (state == F_BITS) && !edge_seen && (to_cnt == TW'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (edge_seen) begin
            to_cnt <= '0;
        end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= F_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bit_cnt  <= '0;
            shift    <= '0;
            par_bit  <= 1'b0;
            stop_bit <= 1'b0;
        end else if (state == F_IDLE) begin
            if (fall) begin
                bit_cnt <= '0;
            end
        end else if (state == F_BITS && fall) begin
            if (bit_cnt < 4'd8) begin
                shift <= {data_s2, shift[7:1]};
            end else if (bit_cnt == 4'd8) begin
                par_bit <= data_s2;
            end else begin
                stop_bit <= data_s2;
            end
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        byte_rdy   = 1'b0;
        rx_err     = 1'b0;
        unique case (state)
            F_IDLE: begin
                if (fall) begin
                    if (!data_s2) begin
                        next_state = F_BITS;
                    end else begin
                        rx_err = 1'b1;
                    end
                end
            end
            F_BITS: begin
                if (timeout) begin
                    next_state = F_IDLE;
                    rx_err     = 1'b1;
                end else if (fall && bit_cnt == 4'd9) begin
                    next_state = F_CHECK;
                end
            end
            F_CHECK: begin
                next_state = F_IDLE;
                if ((^{shift, par_bit}) && stop_bit) begin
                    byte_rdy = 1'b1;
                end else begin
                    rx_err = 1'b1;
                end
            end
            default: next_state = F_IDLE;
        endcase
    end

    assign rx_byte = shift;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard front end: deframes scan-code bytes and folds the E0/F0
// prefixes into one registered key event per make/break code.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 10000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] keycode,
    output logic       key_make,
    output logic       key_ext,
    output logic       key_valid,
    output logic       frame_err
);

    logic [7:0]    rx_byte;
    logic          byte_rdy, rx_err;
    prefix_state_t prefix, next_prefix;
    logic [7:0]    next_keycode;
    logic          next_make, next_ext, next_valid, next_err;

    ps2_rx_frame #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .FILTER_LEN    (FILTER_LEN)
    ) u_rx (
        .clk     (clk),
        .reset   (reset),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .rx_byte (rx_byte),
        .byte_rdy(byte_rdy),
        .rx_err  (rx_err)
    );

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prefix    <= P_NONE;
            keycode   <= 8'h00;
            key_make  <= 1'b0;
            key_ext   <= 1'b0;
            key_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            prefix    <= next_prefix;
            keycode   <= next_keycode;
            key_make  <= next_make;
            key_ext   <= next_ext;
            key_valid <= next_valid;
            frame_err <= next_err;
        end
    end

    always_comb begin
        next_prefix  = prefix;
        next_keycode = keycode;
        next_make    = key_make;
        next_ext     = key_ext;
        next_valid   = 1'b0;
        next_err     = 1'b0;
        if (rx_err) begin
            next_prefix = P_NONE;
            next_err    = 1'b1;
        end else if (byte_rdy) begin
            if (rx_byte == BYTE_E0) begin
                // A stray E0 restarts the extended sequence from scratch.
                next_prefix = P_E0;
            end else if (rx_byte == BYTE_F0) begin
                if (prefix == P_NONE) begin
                    next_prefix = P_F0;
                end else if (prefix == P_E0) begin
                    next_prefix = P_E0F0;
                end
            end else if (is_response(rx_byte)) begin
                next_prefix = P_NONE;
            end else begin
                next_keycode = rx_byte;
                next_ext     = (prefix == P_E0) || (prefix == P_E0F0);
                next_make    = !((prefix == P_F0) || (prefix == P_E0F0));
                next_valid   = 1'b1;
                next_prefix  = P_NONE;
            end
        end
    end

endmodule
